// File: rtl/gbp_seq_pkg.sv
// Shared types and widths for the Game Boy instruction sequencer.
package gbp_seq_pkg;

   localparam int OPCODE_W = 8;
   localparam int COUNT_W  = 16;

   typedef logic [OPCODE_W-1:0] opcode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/gbp_seq_if.sv
// Opcode push handshake (host -> sequencer) and issue outputs (sequencer -> processor).
interface gbp_seq_if;
   import gbp_seq_pkg::*;

   opcode_t in_opcode;
   logic    in_valid;
   logic    in_ready;
   opcode_t opcode;
   logic    valid;

   modport master (output in_opcode, output in_valid, input in_ready,
                   input opcode, input valid);
   modport slave  (input in_opcode, input in_valid, output in_ready,
                   output opcode, output valid);
endinterface

// File: rtl/gbp_seq_fifo.sv
// Synchronous FIFO with wrap-bit pointers, head read and synchronous flush.
module gbp_seq_fifo
   import gbp_seq_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic    clock,
   input  logic    reset,
   input  logic    push,
   input  logic    pop,
   input  logic    flush,
   input  opcode_t wdata,
   output opcode_t rdata,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(DEPTH);

   opcode_t       mem_r [DEPTH];
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign do_push_s = push & ~full & ~flush;
   assign do_pop_s  = pop & ~empty & ~flush;
   assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer update; flush takes priority over any push or pop in the same cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
   end

   // Storage array; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clock) begin
      if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/gbp_sequencer.sv
// Opcode sequencer: FIFO-buffered opcodes issued as single-cycle pulses with a programmable gap.
// Optional flush input enabled by defining GBP_SEQ_FLUSH_EN.
module gbp_sequencer
   import gbp_seq_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int GAP_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   gbp_seq_if.slave           bus,
   input  logic [GAP_W-1:0]   gap,
   input  logic               start,
   input  logic               halt,
`ifdef GBP_SEQ_FLUSH_EN
   input  logic               flush,
`endif
   output logic               busy,
   output logic [COUNT_W-1:0] count
);

   seq_state_t         state_r;
   seq_state_t         next_state_s;
   opcode_t            opcode_r;
   opcode_t            head_s;
   logic               valid_r;
   logic               busy_r;
   logic               run_r;
   logic [GAP_W-1:0]   gap_cnt_r;
   logic [COUNT_W-1:0] count_r;
   logic               full_s;
   logic               empty_s;
   logic               push_s;
   logic               pop_s;
   logic               flush_s;
   logic               go_s;
   logic               can_issue_s;

`ifdef GBP_SEQ_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   assign bus.in_ready = ~full_s & ~flush_s;
   assign push_s       = bus.in_valid & bus.in_ready;
   assign go_s         = (run_r | start) & ~halt;
   assign can_issue_s  = go_s & ~empty_s & ~flush_s;

   gbp_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .flush (flush_s),
      .wdata (bus.in_opcode),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Next-state decision; every transition into ISSUE pops the FIFO head.
   always_comb begin
      next_state_s = IDLE;
      pop_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (can_issue_s) begin
               next_state_s = ISSUE;
               pop_s        = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         ISSUE: begin
            if (halt || flush_s) begin
               next_state_s = IDLE;
            end else if ((gap == {GAP_W{1'b0}}) && can_issue_s) begin
               next_state_s = ISSUE;
               pop_s        = 1'b1;
            end else if (gap != {GAP_W{1'b0}}) begin
               next_state_s = GAP;
            end else begin
               next_state_s = IDLE;
            end
         end
         GAP: begin
            if (halt || flush_s) begin
               next_state_s = IDLE;
            end else if (gap_cnt_r == GAP_W'(1)) begin
               if (can_issue_s) begin
                  next_state_s = ISSUE;
                  pop_s        = 1'b1;
               end else begin
                  next_state_s = IDLE;
               end
            end else begin
               next_state_s = GAP;
            end
         end
         default: begin
            next_state_s = IDLE;
            pop_s        = 1'b0;
         end
      endcase
   end

   // State, registered outputs, gap counter, issue count and run flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         opcode_r  <= '0;
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
         run_r     <= 1'b0;
         gap_cnt_r <= '0;
         count_r   <= '0;
      end else begin
         state_r <= next_state_s;
         valid_r <= (next_state_s == ISSUE);
         busy_r  <= (next_state_s != IDLE);
         if (pop_s) opcode_r <= head_s;
         if (state_r == ISSUE) count_r <= count_r + COUNT_W'(1);
         if ((state_r == ISSUE) && (next_state_s == GAP)) begin
            gap_cnt_r <= gap;
         end else if (state_r == GAP) begin
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
         end
         // halt wins over start
         if (halt) begin
            run_r <= 1'b0;
         end else if (start) begin
            run_r <= 1'b1;
         end
      end
   end

   assign bus.opcode = opcode_r;
   assign bus.valid  = valid_r;
   assign busy       = busy_r;
   assign count      = count_r;

endmodule

// File: tb/tb_gbp_sequencer.sv
// Self-checking bench for gbp_sequencer: directed scenarios plus random traffic against a queue model.
module tb_gbp_sequencer;

   localparam int DEPTH = 8;
   localparam int GAP_W = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic [GAP_W-1:0] gap;
   logic             start;
   logic             halt;
   logic             busy;
   logic [15:0]      count;
`ifdef GBP_SEQ_FLUSH_EN
   logic             flush;
`endif

   gbp_seq_if bus ();

   gbp_sequencer #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .gap   (gap),
      .start (start),
      .halt  (halt),
`ifdef GBP_SEQ_FLUSH_EN
      .flush (flush),
`endif
      .busy  (busy),
      .count (count)
   );

   always #5 clock = ~clock;

   // reference model: issue slot / remaining quiet cycles / queue contents
   logic [7:0]  mq[$];
   logic [7:0]  issued[$];
   bit          m_issuing;
   int          m_quiet;
   bit          m_run;
   logic [7:0]  m_op;
   logic [15:0] m_count;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_issuing = 1'b0;
      m_quiet   = 0;
      m_run     = 1'b0;
      m_op      = 8'h00;
      m_count   = 16'h0000;
   endtask

   // One clock cycle: drive inputs at negedge, predict, then compare after the edge.
   task automatic cycle(input bit iv, input logic [7:0] op, input int g,
                        input bit st, input bit hl, input bit fl);
      bit go, ne, can_push, nxt_issue;
      int nxt_quiet;
      bus.in_valid  = iv;
      bus.in_opcode = op;
      gap           = GAP_W'(g);
      start         = st;
      halt          = hl;
`ifdef GBP_SEQ_FLUSH_EN
      flush         = fl;
`endif
      #1;
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (mq.size() < DEPTH) && !fl});
      go        = (m_run || st) && !hl;
      ne        = (mq.size() != 0);
      can_push  = iv && (mq.size() < DEPTH) && !fl;
      nxt_issue = 1'b0;
      nxt_quiet = 0;
      if (m_issuing) begin
         if (!hl && g == 0) nxt_issue = go && ne;
         if (!hl && g != 0) nxt_quiet = g;
      end else if (m_quiet > 0) begin
         if (!hl && m_quiet == 1) nxt_issue = go && ne;
         if (!hl && m_quiet > 1)  nxt_quiet = m_quiet - 1;
      end else begin
         nxt_issue = go && ne;
      end
      if (fl) begin
         nxt_issue = 1'b0;
         nxt_quiet = 0;
      end
      if (m_issuing) m_count = m_count + 16'd1;
      if (nxt_issue) m_op = mq.pop_front();
      if (fl) mq.delete();
      if (can_push) mq.push_back(op);
      if (hl) m_run = 1'b0;
      else if (st) m_run = 1'b1;
      m_issuing = nxt_issue;
      m_quiet   = nxt_quiet;
      @(posedge clock);
      @(negedge clock);
      chk("valid", {31'd0, bus.valid}, {31'd0, m_issuing});
      chk("opcode", {24'd0, bus.opcode}, {24'd0, m_op});
      chk("busy", {31'd0, busy}, {31'd0, m_issuing || (m_quiet > 0)});
      chk("count", {16'd0, count}, {16'd0, m_count});
      if (bus.valid) issued.push_back(bus.opcode);
   endtask

   task automatic idle(input int n, input int g);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, g, 1'b0, 1'b0, 1'b0);
   endtask

   logic [7:0] b2b_ops [3] = '{8'h3C, 8'h04, 8'h80};
   logic [7:0] full_ops [9];
   logic [7:0] hg_ops [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_opcode = 8'h00;
      gap = '0;
      start = 1'b0;
      halt = 1'b0;
`ifdef GBP_SEQ_FLUSH_EN
      flush = 1'b0;
`endif
      model_reset();
      #3;
      chk("rst_valid", {31'd0, bus.valid}, 32'd0);
      chk("rst_opcode", {24'd0, bus.opcode}, 32'd0);
      chk("rst_count", {16'd0, count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clock);
      reset = 1'b0;

      // back-to-back issue
      for (int i = 0; i < 3; i++) cycle(1'b1, b2b_ops[i], 0, 1'b0, 1'b0, 1'b0);
      issued.delete();
      cycle(1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
      idle(3, 0);
      chk("b2b_n", issued.size(), 32'd3);
      for (int i = 0; i < 3 && i < issued.size(); i++) chk("b2b_op", {24'd0, issued[i]}, {24'd0, b2b_ops[i]});
      chk("b2b_count", {16'd0, count}, 32'd3);
      cycle(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0);

      // gap spacing
      cycle(1'b1, 8'h11, 2, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 2, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 2, 1'b1, 1'b0, 1'b0);
      idle(6, 2);
      cycle(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0);

      // FIFO full, 9th push held until the first pop
      for (int i = 0; i < 9; i++) full_ops[i] = 8'(8'h50 + i);
      for (int i = 0; i < 8; i++) cycle(1'b1, full_ops[i], 0, 1'b0, 1'b0, 1'b0);
      chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
      issued.delete();
      cycle(1'b1, full_ops[8], 0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, full_ops[8], 0, 1'b0, 1'b0, 1'b0);
      idle(12, 0);
      chk("full_n", issued.size(), 32'd9);
      for (int i = 0; i < 9 && i < issued.size(); i++) chk("full_op", {24'd0, issued[i]}, {24'd0, full_ops[i]});
      cycle(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0);

      // halt in first GAP cycle
      for (int i = 0; i < 4; i++) cycle(1'b1, hg_ops[i], 3, 1'b0, 1'b0, 1'b0);
      issued.delete();
      cycle(1'b0, 8'h00, 3, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 3, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 3, 1'b0, 1'b1, 1'b0);
      idle(5, 3);
      chk("halt_n", issued.size(), 32'd1);
      chk("halt_busy", {31'd0, busy}, 32'd0);
      cycle(1'b0, 8'h00, 3, 1'b1, 1'b0, 1'b0);
      chk("halt_resume", {24'd0, bus.opcode}, {24'd0, hg_ops[1]});
      cycle(1'b0, 8'h00, 3, 1'b0, 1'b1, 1'b0);
      idle(4, 0);

      // random traffic
      for (int i = 0; i < 400; i++)
         cycle(($urandom % 2) == 0, 8'($urandom), int'($urandom_range(0, 3)),
               ($urandom % 8) == 0, ($urandom % 16) == 0, 1'b0);

      // asynchronous reset during an ISSUE cycle
      cycle(1'b1, 8'hC1, 0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'hC2, 0, 1'b1, 1'b0, 1'b0);
      begin
         int budget = 20;
         while (!bus.valid && budget > 0) begin
            cycle(1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
            budget--;
         end
         chk("rst_mid_reach_valid", {31'd0, bus.valid}, 32'd1);
      end
      #2 reset = 1'b1;
      #1;
      chk("async_valid", {31'd0, bus.valid}, 32'd0);
      chk("async_count", {16'd0, count}, 32'd0);
      chk("async_busy", {31'd0, busy}, 32'd0);
      chk("async_in_ready", {31'd0, bus.in_ready}, 32'd1);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      idle(4, 0);
      chk("post_rst_count", {16'd0, count}, 32'd0);

`ifdef GBP_SEQ_FLUSH_EN
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h70 + i), 0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h7F, 0, 1'b0, 1'b0, 1'b1);
      chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
      cycle(1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
      idle(2, 0);
      chk("flush_novalid", {31'd0, bus.valid}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gbp_sequencer.md
# gbp_sequencer

Instruction sequencer in front of the Game Boy processor datapath. Accepts 8-bit opcodes from a host or testbench over a valid/ready handshake and buffers them in a small FIFO. Issues them to the processor's `instruction`/`valid` inputs as single-cycle pulses, with a programmable idle gap between issues. Start and halt controls let the bench gate execution without dropping queued instructions.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries. Must be a power of 2 and at least 2.
- `GAP_W`, default 4: width of the `gap` input.

Ports (name, direction, width, meaning):
- `clock` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_opcode` in 8: opcode to enqueue.
- `in_valid` in 1: `in_opcode` is valid this cycle.
- `in_ready` out 1: FIFO can accept. Equals `!full`.
- `gap` in GAP_W: number of idle cycles inserted after each issue. Sampled in the ISSUE cycle.
- `start` in 1: sets the run flag.
- `halt` in 1: clears the run flag and stops issue.
- `opcode` out 8: drives the processor's `instruction` input.
- `valid` out 1: drives the processor's `valid` input.
- `busy` out 1: state is not IDLE.
- `count` out 16: number of instructions issued; wraps from 0xFFFF to 0.

## Operation
Push rule:
- A push occurs when `in_valid && in_ready`.
- No bypass: an opcode pushed into an empty FIFO is visible to the FSM one cycle later.
- FIFO full: `in_ready` = 0 and no push occurs.

Run flag:
- Set by `start`, cleared by `halt`.
- `halt` wins when `start` and `halt` are asserted together.
- Let go = (`run` | `start`) & !`halt`.

State machine:
- **IDLE**
  - Outputs: `valid` = 0.
  - If go & FIFO not empty: load `opcode` from the FIFO head, pop, and go to ISSUE.
- **ISSUE**
  - Outputs: `valid` = 1 for this cycle; `count` increments at the end of the cycle.
  - Next state, checked in this order:
    - `halt` → IDLE.
    - `gap` == 0 & go & FIFO not empty → stay in ISSUE with the next head (back-to-back issue).
    - `gap` > 0 → GAP, with the gap counter loaded from `gap`.
    - Otherwise → IDLE.
- **GAP**
  - Outputs: `valid` = 0; the counter decrements each cycle.
  - `halt` → IDLE immediately.
  - When the counter is 1: if go & FIFO not empty → ISSUE (load and pop), else → IDLE.

Other rules:
- `opcode` holds its last issued value when `valid` = 0.
- A halt never discards FIFO contents.
- An ISSUE cycle already in progress when `halt` rises still completes with `valid` = 1.

## Timing
Reset values:
- `valid` = 0, `opcode` = 0x00, `count` = 0, `busy` = 0, `in_ready` = 1.
- FIFO empty, run flag = 0, state = IDLE.

Reset behaviour:
- Asynchronous: outputs take their reset values immediately, including mid-ISSUE.
- Queued entries are lost.

Latency and spacing:
- `start` in cycle t with a non-empty FIFO → `valid` = 1 in cycle t+1.
- Push into an empty FIFO in cycle t while running → `valid` = 1 in cycle t+2.
- With `gap` = N, consecutive `valid` pulses are exactly N+1 cycles apart.

FIFO boundaries:
- Pointers are log2(DEPTH) bits, with an extra wrap bit for full/empty detection.
- Pop and push in the same cycle are legal when the FIFO is not full.
- Occupancy is unchanged by a simultaneous push and pop.

## Configuration
Macro `GBP_SEQ_FLUSH_EN`:
- **Defined:** adds input port `flush` (1 bit).
  - `flush` empties the FIFO at the next edge and forces `in_ready` = 0 during the flush cycle, so any push in that cycle is dropped.
  - An ISSUE in progress completes, and the FSM then goes to IDLE.
  - The run flag and `count` are unchanged.
- **Undefined:** the `flush` port and its logic are absent.

## Structure
- Package `gbp_seq_pkg` contains:
  - `OPCODE_W` = 8 and `COUNT_W` = 16.
  - typedef `opcode_t`.
  - enum `seq_state_t` {IDLE, ISSUE, GAP}.
- Sub-module `gbp_seq_fifo`: a synchronous FIFO with push/pop, full/empty, head data, and an optional flush input.
- The FSM, run flag, gap counter and `count` live in `gbp_sequencer`.

## Test plan
- **Back-to-back issue:** `gap` = 0; push 0x3C, 0x04, 0x80, then pulse `start` → `valid` high for 3 consecutive cycles with `opcode` 0x3C, 0x04, 0x80 in order; `count` = 3; `busy` falls the following cycle.
- **Gap spacing:** `gap` = 2; queue 2 opcodes; pulse `start` in cycle 0 → `valid` high in cycles 1 and 4 only.
- **FIFO full:** DEPTH = 8; push 9 opcodes without `start` → `in_ready` = 0 after the 8th push and the 9th is held; after `start`, the 9th is accepted the cycle after the first pop, and all 9 issue in order.
- **Halt in GAP:** `gap` = 3; queue 4 opcodes, `start`, assert `halt` in the first GAP cycle → exactly 1 issue, state IDLE, 3 entries remain; a later `start` issues the 2nd opcode next.
- **Reset mid-ISSUE:** assert `reset` asynchronously during a `valid` cycle → `valid`, `count` and `busy` are 0 and `in_ready` is 1 with no clock edge required; after release, no issue occurs until new pushes and a `start`.
- **Flush (`GBP_SEQ_FLUSH_EN`):** queue 5 opcodes, pulse `flush` → FIFO empty, `in_ready` = 1 the next cycle, `start` produces no `valid`.
